// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The sub port exists only when PIPE_ADD_SUB_EN is defined.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef PIPE_ADD_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Handshake: a transfer happens on a rising clk edge when valid and ready are
    // both 1. The producer holds its payload stable while valid=1 and ready=0.
    modport master (
        output in_valid, a, b, cin,
`ifdef PIPE_ADD_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin,
`ifdef PIPE_ADD_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/pipelined_adder.sv
// Segment-pipelined WIDTH-bit adder: one SEG-bit slice per stage, carry passed stage to stage.
// Optional subtract mode (a + ~b + 1) is enabled with the PIPE_ADD_SUB_EN macro.
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input logic              clk,
    input logic              rst_n,
    pipelined_adder_if.slave bus
);
    localparam int STAGES = (SEG >= 1) ? WIDTH / SEG : 1;
    localparam int BW_N   = (STAGES > 1) ? STAGES - 1 : 1;

    if (SEG < 1) begin : g_chk_seg
        $fatal(1, "pipelined_adder: SEG must be at least 1");
    end else if (WIDTH % SEG != 0) begin : g_chk_width
        $fatal(1, "pipelined_adder: WIDTH must be a multiple of SEG");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] cy;
    logic [WIDTH-1:0]  aw [STAGES];
    logic [WIDTH-1:0]  bw [BW_N];

`ifdef PIPE_ADD_SUB_EN
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_eff   = bus.b;
    assign cin_eff = bus.cin;
`endif

    // The whole pipe moves as one unit: it advances unless the output is stalled.
    assign adv          = !vld[STAGES-1] || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = vld[STAGES-1];
    assign bus.sum      = aw[STAGES-1];
    assign bus.cout     = cy[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] xa;
        logic [SEG-1:0]   xb;
        logic             xc;
        logic             xv;
        logic [SEG:0]     ssum;
        logic [WIDTH-1:0] nxt_a;
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] a_q;

        if (k == 0) begin : g_first
            assign xa = bus.a;
            assign xb = b_eff[SEG-1:0];
            assign xc = cin_eff;
            assign xv = bus.in_valid;
        end else begin : g_next
            assign xa = aw[k-1];
            assign xb = bw[k-1][SEG-1:0];
            assign xc = cy[k-1];
            assign xv = vld[k-1];
        end

        assign ssum = {1'b0, xa[SEG-1:0]} + {1'b0, xb} + {{SEG{1'b0}}, xc};

        // The A word rotates: the fresh slice sum enters at the top while the
        // unconsumed A slices shift down, so after the last stage it holds the sum.
        if (SEG == WIDTH) begin : g_rot_full
            assign nxt_a = ssum[SEG-1:0];
        end else begin : g_rot
            assign nxt_a = {ssum[SEG-1:0], xa[WIDTH-1:SEG]};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                a_q <= '0;
            end else if (adv) begin
                v_q <= xv;
                if (xv) begin
                    c_q <= ssum[SEG];
                    a_q <= nxt_a;
                end
            end
        end

        assign vld[k] = v_q;
        assign cy[k]  = c_q;
        assign aw[k]  = a_q;

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] bsrc;
            logic [WIDTH-1:0] b_q;

            if (k == 0) begin : g_bsrc_in
                assign bsrc = b_eff;
            end else begin : g_bsrc_pipe
                assign bsrc = bw[k-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b_q <= '0;
                end else if (adv && xv) begin
                    b_q <= bsrc >> SEG;
                end
            end

            assign bw[k] = b_q;
        end
    end

    if (STAGES == 1) begin : g_no_bw
        assign bw[0] = '0;
    end
endmodule
